// File: rtl/mtimer.sv
// RISC-V machine timer (mtime / mtimecmp) as a Wishbone B4 classic slave.
// Register block of four 32-bit words at BASE_ADDRESS:
//   0x0 mtime[31:0], 0x4 mtime[63:32], 0x8 mtimecmp[31:0], 0xC mtimecmp[63:32].
// Optional feature macro: MTIMER_READ_LATCH_EN -- a read of 0x0 snapshots mtime[63:32]
// into a shadow register that a following read of 0x4 returns (tear-free 64-bit read).
module mtimer #(
  parameter logic [31:0] BASE_ADDRESS = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stb_i,
  input  logic        cyc_i,
  input  logic [31:0] adr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  input  logic        we_i,
  output logic        ack_o,
  output logic        err_o,
  output logic        rty_o,
  input  logic        interrupt_enable,
  output logic        interrupt
);

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] rd_val;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic        req, in_range, wr, rd;
  logic [1:0]  idx;

  // Byte address bits below word granularity carry no meaning here.
  logic unused_adr;
  assign unused_adr = ^adr_i[1:0];

  // Replace the selected byte lanes of a word with new data.
  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] sel);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

  // A new request is only accepted while no response is outstanding.
  assign req      = stb_i & cyc_i & ~ack_q & ~err_q;
  assign in_range = (adr_i[31:4] == BASE_ADDRESS[31:4]);
  assign wr       = req & in_range & we_i;
  assign rd       = req & in_range & ~we_i;
  assign idx      = adr_i[3:2];

`ifdef MTIMER_READ_LATCH_EN
  logic [31:0] shadow_q, shadow_d;

  // Snapshot the upper half whenever the lower half is read.
  always_comb begin
    shadow_d = shadow_q;
    if (rd && idx == 2'd0) shadow_d = mtime_q[63:32];
  end

  // Shadow register for tear-free 64-bit reads.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) shadow_q <= 32'h0;
    else        shadow_q <= shadow_d;
  end
`endif

  // Read mux of the addressed register as it stands before this edge.
  always_comb begin
    rd_val = 32'h0;
    unique case (idx)
`ifdef MTIMER_READ_LATCH_EN
      2'd1:    rd_val = shadow_q;
`else
      2'd1:    rd_val = mtime_q[63:32];
`endif
      2'd2:    rd_val = mtimecmp_q[31:0];
      2'd3:    rd_val = mtimecmp_q[63:32];
      default: rd_val = mtime_q[31:0];
    endcase
  end

  // Next state: counter increments unless a write to either mtime half overrides it.
  always_comb begin
    mtime_d    = mtime_q + 64'd1;
    mtimecmp_d = mtimecmp_q;
    if (wr) begin
      unique case (idx)
        2'd0:    mtime_d = {mtime_q[63:32], merge(mtime_q[31:0], dat_i, sel_i)};
        2'd1:    mtime_d = {merge(mtime_q[63:32], dat_i, sel_i), mtime_q[31:0]};
        2'd2:    mtimecmp_d = {mtimecmp_q[63:32], merge(mtimecmp_q[31:0], dat_i, sel_i)};
        default: mtimecmp_d = {merge(mtimecmp_q[63:32], dat_i, sel_i), mtimecmp_q[31:0]};
      endcase
    end
    ack_d   = req & in_range;
    err_d   = req & ~in_range;
    rdata_d = rd ? rd_val : 32'h0;
  end

  // Timer, compare and bus response registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mtime_q    <= 64'h0;
      mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= 32'h0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
    end
  end

  // Responses vanish as soon as the master drops the strobe.
  assign ack_o     = ack_q & stb_i & cyc_i;
  assign err_o     = err_q & stb_i & cyc_i;
  assign dat_o     = ack_o ? rdata_q : 32'h0;
  assign rty_o     = 1'b0;
  assign interrupt = interrupt_enable & (mtime_q >= mtimecmp_q);

endmodule

// File: tb/tb_mtimer.sv
// Directed self-checking bench for mtimer.
module tb_mtimer;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        stb_i = 1'b0;
  logic        cyc_i = 1'b0;
  logic [31:0] adr_i = 32'h0;
  logic [3:0]  sel_i = 4'h0;
  logic [31:0] dat_i = 32'h0;
  logic [31:0] dat_o;
  logic        we_i = 1'b0;
  logic        ack_o;
  logic        err_o;
  logic        rty_o;
  logic        interrupt_enable = 1'b0;
  logic        interrupt;

  int errors = 0;
  int checks = 0;

  mtimer #(.BASE_ADDRESS(32'h0)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .stb_i            (stb_i),
    .cyc_i            (cyc_i),
    .adr_i            (adr_i),
    .sel_i            (sel_i),
    .dat_i            (dat_i),
    .dat_o            (dat_o),
    .we_i             (we_i),
    .ack_o            (ack_o),
    .err_o            (err_o),
    .rty_o            (rty_o),
    .interrupt_enable (interrupt_enable),
    .interrupt        (interrupt)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%08h expected=%08h", name, obs, exp);
    end
  endtask

  // One bus transfer: drive on a falling edge, sample 1 ns after the commit edge,
  // then drop the strobe and confirm the response disappears at once.
  task automatic xfer(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                      input logic [31:0] wdat, input logic exp_ok, input logic [31:0] exp_rd,
                      input string name);
    @(negedge clk_i);
    stb_i = 1'b1; cyc_i = 1'b1; we_i = we; adr_i = adr; sel_i = sel; dat_i = wdat;
    #1;
    chk({name, ".ack_before_edge"}, {31'b0, ack_o | err_o}, 32'd0);
    @(posedge clk_i);
    #1;
    chk({name, ".ack"}, {31'b0, ack_o}, {31'b0, exp_ok});
    chk({name, ".err"}, {31'b0, err_o}, {31'b0, ~exp_ok});
    if (!we) chk({name, ".rdata"}, dat_o, exp_ok ? exp_rd : 32'h0);
    @(negedge clk_i);
    stb_i = 1'b0; cyc_i = 1'b0; we_i = 1'b0;
    #1;
    chk({name, ".resp_drop"}, {30'b0, ack_o, err_o}, 32'd0);
    chk({name, ".dat_drop"}, dat_o, 32'h0);
  endtask

  initial begin
    // Reset state
    interrupt_enable = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst.ack", {31'b0, ack_o}, 32'd0);
    chk("rst.err", {31'b0, err_o}, 32'd0);
    chk("rst.rty", {31'b0, rty_o}, 32'd0);
    chk("rst.dat", dat_o, 32'h0);
    chk("rst.irq", {31'b0, interrupt}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;

    // 1. Counter runs after clearing the low half
    xfer(1'b1, 32'h0, 4'hF, 32'h0, 1'b1, 32'h0, "t1.wr_lo");
    repeat (5) @(posedge clk_i);
    xfer(1'b0, 32'h0, 4'hF, 32'h0, 1'b1, 32'd5, "t1.rd_lo");

    // 2. Compare high word nonzero keeps the interrupt low
    xfer(1'b1, 32'hC, 4'hF, 32'd1, 1'b1, 32'h0, "t2.wr_cmphi");
    chk("t2.irq", {31'b0, interrupt}, 32'd0);

    // 3. mtime climbs past mtimecmp
    xfer(1'b1, 32'h0, 4'hF, 32'd1000, 1'b1, 32'h0, "t3.wr_lo");
    xfer(1'b1, 32'h8, 4'hF, 32'd1010, 1'b1, 32'h0, "t3.wr_cmplo");
    xfer(1'b1, 32'hC, 4'hF, 32'd0, 1'b1, 32'h0, "t3.wr_cmphi");
    chk("t3.irq_early", {31'b0, interrupt}, 32'd0);
    repeat (10) @(posedge clk_i);
    #1;
    chk("t3.irq", {31'b0, interrupt}, 32'd1);

    // 4. Rewinding mtime and dropping the enable both clear the interrupt
    xfer(1'b1, 32'h0, 4'hF, 32'd1000, 1'b1, 32'h0, "t4.wr_lo");
    chk("t4.irq_rewind", {31'b0, interrupt}, 32'd0);
    repeat (12) @(posedge clk_i);
    #1;
    chk("t4.irq_again", {31'b0, interrupt}, 32'd1);
    interrupt_enable = 1'b0;
    #1;
    chk("t4.irq_disabled", {31'b0, interrupt}, 32'd0);
    interrupt_enable = 1'b1;

    // 5. Carry from low into high half, then a single-lane write
    xfer(1'b1, 32'h4, 4'hF, 32'h0, 1'b1, 32'h0, "t5.wr_hi");
    xfer(1'b1, 32'h0, 4'hF, 32'hFFFF_FFFF, 1'b1, 32'h0, "t5.wr_lo");
    xfer(1'b0, 32'h0, 4'hF, 32'h0, 1'b1, 32'd0, "t5.rd_lo");
    xfer(1'b0, 32'h4, 4'hF, 32'h0, 1'b1, 32'd1, "t5.rd_hi");
    chk("t5.irq", {31'b0, interrupt}, 32'd1);
    xfer(1'b1, 32'h8, 4'b0001, 32'hAABB_CCDD, 1'b1, 32'h0, "t5.wr_byte");
    xfer(1'b0, 32'h8, 4'hF, 32'h0, 1'b1, 32'h0000_03DD, "t5.rd_cmplo");
    xfer(1'b0, 32'hC, 4'hF, 32'h0, 1'b1, 32'h0, "t5.rd_cmphi");

    // 6. Out-of-range accesses error out and change nothing
    xfer(1'b1, 32'h10, 4'hF, 32'h1234_5678, 1'b0, 32'h0, "t6.wr_oor");
    xfer(1'b1, 32'h18, 4'hF, 32'hFFFF_FFFF, 1'b0, 32'h0, "t6.wr_oor_hi");
    xfer(1'b0, 32'h18, 4'hF, 32'h0, 1'b0, 32'h0, "t6.rd_oor");
    xfer(1'b0, 32'h8, 4'hF, 32'h0, 1'b1, 32'h0000_03DD, "t6.rd_cmplo");
    chk("t6.irq", {31'b0, interrupt}, 32'd1);

    // Reset in the middle of a transfer drops the ack and restores registers
    @(negedge clk_i);
    stb_i = 1'b1; cyc_i = 1'b1; we_i = 1'b0; adr_i = 32'h8; sel_i = 4'hF;
    @(posedge clk_i);
    #1;
    chk("rst_mid.ack_up", {31'b0, ack_o}, 32'd1);
    rst_i = 1'b0;
    #1;
    chk("rst_mid.ack_drop", {31'b0, ack_o}, 32'd0);
    chk("rst_mid.dat", dat_o, 32'h0);
    chk("rst_mid.irq", {31'b0, interrupt}, 32'd0);
    stb_i = 1'b0; cyc_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    xfer(1'b0, 32'h0, 4'hF, 32'h0, 1'b1, 32'd1, "rst_mid.rd_lo");
    xfer(1'b0, 32'h8, 4'hF, 32'h0, 1'b1, 32'hFFFF_FFFF, "rst_mid.rd_cmplo");
    xfer(1'b0, 32'hC, 4'hF, 32'h0, 1'b1, 32'hFFFF_FFFF, "rst_mid.rd_cmphi");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
